axis_fifo_wr_arbiter: RTL and testbench
=======================================

# axis_fifo_wr_arbiter

Packet-granular two-port round-robin arbiter that shares the single write port of the team's synchronous FIFO (data + last flag) between two AXI-Stream sources. Sits between the upstream AXIS producers (UART RX framer, loopback/command injector) and the FIFO. It never interleaves beats of different packets: a grant is held from the first beat until the beat carrying tlast. An optional compile-time packet-length guard truncates runaway packets.

## Interface
- WIDTH, 8: data width of both AXIS inputs and the FIFO write port.
- MAX_BEATS, 16: packet-length limit, used only when the guard is compiled in; legal range 1–255.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s0_tdata  input  WIDTH  port 0 data.
- s0_tvalid  input  1  port 0 beat valid.
- s0_tlast  input  1  port 0 end-of-packet.
- s0_tready  output  1  port 0 beat accepted when s0_tvalid && s0_tready.
- s1_tdata / s1_tvalid / s1_tlast / s1_tready  as port 0, for port 1.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_din  output  WIDTH  FIFO write data.
- fifo_din_last  output  1  FIFO write last flag.
- fifo_full  input  1  FIFO full flag.
- grant  output  2  one-hot current owner (01 = port 0, 10 = port 1, 00 = none); registered.
- trunc_err  output  1  sticky; set when a packet is truncated by the guard.

## Operation
- States: IDLE, OWN0, OWN1. Reset → IDLE, priority pointer → port 0, trunc_err → 0, beat counter → 0.
- IDLE: no tready asserted. If exactly one sN_tvalid is high, go to OWNN. If both are high, grant the port selected by the priority pointer. If neither is high, stay in IDLE.
- OWNN:
  - sN_tready = !fifo_full.
  - The other port's tready = 0.
  - fifo_wr_en = sN_tvalid && sN_tready (combinational).
  - fifo_din / fifo_din_last are driven from port N.
- Accepted beat with tlast = 1: return to IDLE on the next edge and set the priority pointer to the other port.
- Accepted beat with tlast = 0: stay in OWNN.
- Outside OWN0/OWN1: fifo_wr_en = 0, fifo_din = 0, fifo_din_last = 0.
- fifo_full high: no beat is accepted, grant is held, and no state change occurs. When full deasserts, transfer resumes the same cycle.
- sN_tvalid dropping mid-packet: grant is held; no timeout.
- Single requester: the pointer still toggles after each packet. This is harmless; a lone requester is always granted.
- Reset mid-packet: the next cycle is in IDLE, all treadys are 0, and the grant is cleared. The partial packet already in the FIFO is left without a last flag; upstream flushing is not this block's responsibility.

## Timing
- Grant latency: tvalid first high in IDLE at cycle N → grant and tready at N+1; first beat is written at N+1 if the FIFO is not full.
- Throughput: one beat per cycle within a packet.
- Inter-packet gap: exactly one idle cycle (the IDLE arbitration cycle) after every tlast beat.
- Reset values:
  - s0_tready = s1_tready = 0.
  - fifo_wr_en = 0, fifo_din = 0, fifo_din_last = 0.
  - grant = 00, trunc_err = 0.
- tready depends combinationally on fifo_full; no combinational path exists from tvalid to tready.

## Configuration
- Macro AXIS_ARB_PKT_LIMIT_EN.
- Defined:
  - An 8-bit beat counter clears on entering OWNx and increments per accepted beat.
  - On the MAX_BEATS-th accepted beat, if that beat's tlast = 0: force fifo_din_last = 1, set trunc_err, and go to IDLE with the pointer toggled.
  - The remaining beats of that source are then arbitrated as a new packet.
  - trunc_err clears only on rst.
- Undefined: no counter is built, trunc_err is tied to 0, and packets of any length pass unmodified.

## Test plan
- Port 0 only, packet A0,A1,A2 (last on A2), FIFO not full:
  - grant = 01 one cycle after tvalid.
  - Three consecutive fifo_wr_en pulses; fifo_din_last = 1 only with A2.
  - grant = 00 the next cycle.
- Both ports valid from the first cycle after reset, 2-beat packets:
  - Port 0 packet written first.
  - One idle cycle, then port 1 packet.
  - No interleaving in the FIFO.
- Both ports continuously valid with 1-beat packets for 10 packets → FIFO order 0,1,0,1,…; each port wins 5.
- fifo_full high for 3 cycles mid-packet on port 1:
  - s1_tready = 0 and fifo_wr_en = 0 for those 3 cycles.
  - grant stays 10.
  - The next beat is written in the cycle full drops.
- With AXIS_ARB_PKT_LIMIT_EN and MAX_BEATS = 4, send a 6-beat packet on port 0:
  - Beat 4 is written with fifo_din_last = 1 and trunc_err = 1.
  - After one idle cycle, beats 5–6 are written with last on beat 6.
  - Without the macro, one 6-beat packet is written and trunc_err stays 0.
- Assert rst for one cycle after 2 of 5 beats on port 1:
  - Next cycle: grant = 00, both treadys 0, pointer at port 0.
  - A fresh port 0 and port 1 request is served port 0 first.

Source files
------------

// File: rtl/axis_fifo_wr_arbiter.sv
// rtl/axis_fifo_wr_arbiter.sv - packet-granular round-robin arbiter for one FIFO write port
//
// Purpose:
//   Shares the write port of a synchronous FIFO (data + last flag) between two
//   AXI-Stream sources. A grant is held from the first beat of a packet until
//   the beat carrying tlast, so packets from the two sources never interleave.
//   Ties in IDLE are broken by a priority pointer that moves to the other port
//   after every completed packet.
//
// Optional feature (macro AXIS_ARB_PKT_LIMIT_EN):
//   Defined   : an 8-bit beat counter truncates packets at MAX_BEATS beats,
//               forcing fifo_din_last on the last allowed beat and setting the
//               sticky trunc_err flag. The rest of the source's beats are then
//               arbitrated as a new packet.
//   Undefined : no counter, trunc_err tied low, packets pass unmodified.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s0_tdata/tvalid/tlast      port 0 AXIS input,  s0_tready output
//   s1_tdata/tvalid/tlast      port 1 AXIS input,  s1_tready output
//   fifo_wr_en, fifo_din,      FIFO write strobe, data and last flag
//   fifo_din_last
//   fifo_full                  FIFO full flag (stalls the owning port)
//   grant                      registered one-hot owner (01 port 0, 10 port 1)
//   trunc_err                  sticky packet-truncation flag
module axis_fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_din_last,
  input  logic             fifo_full,
  output logic [1:0]       grant,
  output logic             trunc_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Legal packet-length range for the guard.
  localparam bit MAX_BEATS_OK = (MAX_BEATS >= 1) && (MAX_BEATS <= 255);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;       // 0: port 0 wins a tie, 1: port 1 wins
  logic [1:0]       grant_q, grant_d;

  logic             own_any;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             limit_hit;
  logic             pkt_end;

  // Steer the owning port onto a common set of signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    case (state_q)
      OWN0: begin
        sel_valid = s0_tvalid;
        sel_last  = s0_tlast;
        sel_data  = s0_tdata;
      end
      OWN1: begin
        sel_valid = s1_tvalid;
        sel_last  = s1_tlast;
        sel_data  = s1_tdata;
      end
      default: ;
    endcase
  end

  assign own_any = (state_q == OWN0) || (state_q == OWN1);
  // tready is !fifo_full while owning, so a beat is accepted exactly when the
  // owner is valid and the FIFO has room.
  assign accept  = own_any && sel_valid && !fifo_full;
  // A packet ends on its tlast beat or on a beat cut short by the length guard.
  assign pkt_end = accept && (sel_last || limit_hit);

`ifdef AXIS_ARB_PKT_LIMIT_EN
  localparam logic [7:0] LAST_BEAT_IDX = 8'(MAX_BEATS - 1);

  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       trunc_q, trunc_d;

  // beat_cnt_q holds the number of beats already accepted in this grant, so
  // the MAX_BEATS-th beat is the one seen while the count is MAX_BEATS-1.
  assign limit_hit = MAX_BEATS_OK && (beat_cnt_q == LAST_BEAT_IDX);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    trunc_d    = trunc_q;
    if (!own_any) begin
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
    if (accept && limit_hit && !sel_last) begin
      trunc_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign trunc_err = trunc_q;
`else
  assign limit_hit = 1'b0;
  // Constant 0; MAX_BEATS only matters when the guard is built.
  assign trunc_err = 1'b0 && MAX_BEATS_OK;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          state_d = ptr_q ? OWN1 : OWN0;
        end else if (s0_tvalid) begin
          state_d = OWN0;
        end else if (s1_tvalid) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (pkt_end) begin
          state_d = IDLE;
          ptr_d   = 1'b1;
        end
      end
      OWN1: begin
        if (pkt_end) begin
          state_d = IDLE;
          ptr_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // grant is kept as its own register so it is a clean flop output.
  assign grant_d = {state_d == OWN1, state_d == OWN0};
  assign grant   = grant_q;

  // Output logic. Nothing here depends on tvalid except the write strobe,
  // so there is no tvalid-to-tready path.
  always_comb begin
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_din      = '0;
    fifo_din_last = 1'b0;
    case (state_q)
      OWN0: s0_tready = !fifo_full;
      OWN1: s1_tready = !fifo_full;
      default: ;
    endcase
    if (own_any) begin
      fifo_wr_en    = accept;
      fifo_din      = sel_data;
      fifo_din_last = sel_last || limit_hit;
    end
  end

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// tb/tb_axis_fifo_wr_arbiter.sv - self-checking bench for axis_fifo_wr_arbiter
module tb_axis_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
`ifdef AXIS_ARB_PKT_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] s0_tdata;
  logic             s0_tvalid;
  logic             s0_tlast;
  logic             s0_tready;
  logic [WIDTH-1:0] s1_tdata;
  logic             s1_tvalid;
  logic             s1_tlast;
  logic             s1_tready;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_din_last;
  logic             fifo_full;
  logic [1:0]       grant;
  logic             trunc_err;

  axis_fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s0_tdata      (s0_tdata),
    .s0_tvalid     (s0_tvalid),
    .s0_tlast      (s0_tlast),
    .s0_tready     (s0_tready),
    .s1_tdata      (s1_tdata),
    .s1_tvalid     (s1_tvalid),
    .s1_tlast      (s1_tlast),
    .s1_tready     (s1_tready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .fifo_din_last (fifo_din_last),
    .fifo_full     (fifo_full),
    .grant         (grant),
    .trunc_err     (trunc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t src0[$];
  beat_t src1[$];
  beat_t exp_q[$];
  beat_t mon_e;
  bit    acc0, acc1;
  logic  full_drive;
  int    total;
  int    passed;

  function automatic beat_t mk(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    return b;
  endfunction

  // Scoreboard: every FIFO write is popped against the expected order.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL fifo_write_unexpected: got din=%h last=%b, required no write", fifo_din, fifo_din_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({fifo_din, fifo_din_last} !== {mon_e.d, mon_e.l})
          $display("FAIL fifo_write: got din=%h last=%b, required din=%h last=%b", fifo_din, fifo_din_last, mon_e.d, mon_e.l);
        else
          passed++;
      end
    end
  end

  // One clock: retire last cycle's handshakes, drive the heads of the source
  // queues just after the edge, then return at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (acc0 && src0.size() > 0) void'(src0.pop_front());
    if (acc1 && src1.size() > 0) void'(src1.pop_front());
    s0_tvalid = (src0.size() > 0);
    s0_tdata  = (src0.size() > 0) ? src0[0].d : '0;
    s0_tlast  = (src0.size() > 0) ? src0[0].l : 1'b0;
    s1_tvalid = (src1.size() > 0);
    s1_tdata  = (src1.size() > 0) ? src1[0].d : '0;
    s1_tlast  = (src1.size() > 0) ? src1[0].l : 1'b0;
    fifo_full = full_drive;
    @(negedge clk);
    acc0 = s0_tvalid && s0_tready;
    acc1 = s1_tvalid && s1_tready;
  endtask

  task automatic do_reset();
    src0.delete();
    src1.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    src0.push_back(mk(8'hEE, 1'b1));
    step();
    step();
    total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b, required 00", grant); else passed++;
    total++; if (s0_tready !== 1'b0) $display("FAIL reset_s0_tready: got %b, required 0", s0_tready); else passed++;
    total++; if (s1_tready !== 1'b0) $display("FAIL reset_s1_tready: got %b, required 0", s1_tready); else passed++;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b, required 0", fifo_wr_en); else passed++;
    total++; if (fifo_din !== 8'h00) $display("FAIL reset_din: got %h, required 00", fifo_din); else passed++;
    total++; if (fifo_din_last !== 1'b0) $display("FAIL reset_din_last: got %b, required 0", fifo_din_last); else passed++;
    total++; if (trunc_err !== 1'b0) $display("FAIL reset_trunc_err: got %b, required 0", trunc_err); else passed++;
    rst = 1'b0;
    src0.delete();
    s0_tvalid = 1'b0;
    s0_tlast  = 1'b0;
    s0_tdata  = '0;
    acc0 = 1'b0;
  endtask

  task automatic test_single_port0();
    int wr;
    wr = 0;
    for (int i = 1; i <= 3; i++) begin
      src0.push_back(mk(8'(i), i == 3));
      exp_q.push_back(mk(8'(i), i == 3));
    end
    step();
    total++; if (grant !== 2'b00) $display("FAIL single_grant_latency: got %b, required 00", grant); else passed++;
    total++; if (s0_tready !== 1'b0) $display("FAIL single_tready_latency: got %b, required 0", s0_tready); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        total++; if (grant !== 2'b01) $display("FAIL single_grant: got %b, required 01", grant); else passed++;
      end
      if (fifo_wr_en === 1'b1) wr++;
    end
    total++; if (wr !== 3) $display("FAIL single_wr_pulses: got %0d, required 3", wr); else passed++;
    step();
    total++; if (grant !== 2'b00) $display("FAIL single_grant_release: got %b, required 00", grant); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_both_two_beat();
    do_reset();
    src0.push_back(mk(8'h10, 1'b0));
    src0.push_back(mk(8'h11, 1'b1));
    src1.push_back(mk(8'h20, 1'b0));
    src1.push_back(mk(8'h21, 1'b1));
    exp_q.push_back(mk(8'h10, 1'b0));
    exp_q.push_back(mk(8'h11, 1'b1));
    exp_q.push_back(mk(8'h20, 1'b0));
    exp_q.push_back(mk(8'h21, 1'b1));
    step();
    step();
    total++; if (grant !== 2'b01) $display("FAIL both_first_grant: got %b, required 01", grant); else passed++;
    step();
    step();
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL both_gap_wr_en: got %b, required 0", fifo_wr_en); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL both_gap_grant: got %b, required 00", grant); else passed++;
    step();
    total++; if (grant !== 2'b10) $display("FAIL both_second_grant: got %b, required 10", grant); else passed++;
    step();
    step();
    total++; if (exp_q.size() !== 0) $display("FAIL both_drain: got %0d pending, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_round_robin();
    int n0, n1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 5; i++) begin
      src0.push_back(mk(8'h00 + 8'(i), 1'b1));
      src1.push_back(mk(8'h80 + 8'(i), 1'b1));
      exp_q.push_back(mk(8'h00 + 8'(i), 1'b1));
      exp_q.push_back(mk(8'h80 + 8'(i), 1'b1));
    end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step();
      if (fifo_wr_en === 1'b1) begin
        if (fifo_din[7]) n1++;
        else n0++;
      end
    end
    total++; if (n0 !== 5) $display("FAIL rr_port0_wins: got %0d, required 5", n0); else passed++;
    total++; if (n1 !== 5) $display("FAIL rr_port1_wins: got %0d, required 5", n1); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL rr_drain: got %0d pending, required 0", exp_q.size()); else passed++;
    step();
    total++; if (grant !== 2'b00) $display("FAIL rr_final_grant: got %b, required 00", grant); else passed++;
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      src1.push_back(mk(8'hA0 + 8'(i), i == 3));
      exp_q.push_back(mk(8'hA0 + 8'(i), i == 3));
    end
    step();
    step();
    total++; if (grant !== 2'b10) $display("FAIL full_grant: got %b, required 10", grant); else passed++;
    total++; if (fifo_wr_en !== 1'b1) $display("FAIL full_first_beat: got %b, required 1", fifo_wr_en); else passed++;
    full_drive = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (s1_tready !== 1'b0) $display("FAIL full_tready_c%0d: got %b, required 0", i, s1_tready); else passed++;
      total++; if (fifo_wr_en !== 1'b0) $display("FAIL full_wr_en_c%0d: got %b, required 0", i, fifo_wr_en); else passed++;
      total++; if (grant !== 2'b10) $display("FAIL full_grant_c%0d: got %b, required 10", i, grant); else passed++;
    end
    full_drive = 1'b0;
    step();
    total++; if (fifo_wr_en !== 1'b1) $display("FAIL full_resume: got %b, required 1", fifo_wr_en); else passed++;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) step();
    step();
    total++; if (exp_q.size() !== 0) $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL full_release: got %b, required 00", grant); else passed++;
  endtask

  task automatic test_truncation();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      src0.push_back(mk(8'h30 + 8'(i), i == 6));
      exp_q.push_back(mk(8'h30 + 8'(i), (i == 6) || (LIMIT_EN && i == 4)));
    end
    step();
    for (int i = 0; i < 4; i++) step();
    step();
    total++; if (fifo_wr_en !== !LIMIT_EN) $display("FAIL trunc_gap_wr_en: got %b, required %b", fifo_wr_en, !LIMIT_EN); else passed++;
    total++; if (trunc_err !== LIMIT_EN) $display("FAIL trunc_err_set: got %b, required %b", trunc_err, LIMIT_EN); else passed++;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) step();
    step();
    total++; if (exp_q.size() !== 0) $display("FAIL trunc_drain: got %0d pending, required 0", exp_q.size()); else passed++;
    total++; if (trunc_err !== LIMIT_EN) $display("FAIL trunc_err_sticky: got %b, required %b", trunc_err, LIMIT_EN); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL trunc_release: got %b, required 00", grant); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 1; i <= 5; i++) src1.push_back(mk(8'hC0 + 8'(i), i == 5));
    exp_q.push_back(mk(8'hC1, 1'b0));
    exp_q.push_back(mk(8'hC2, 1'b0));
    step();
    step();
    total++; if (grant !== 2'b10) $display("FAIL rstmid_grant: got %b, required 10", grant); else passed++;
    step();
    rst = 1'b1;
    step();
    total++; if (grant !== 2'b00) $display("FAIL rstmid_grant_clear: got %b, required 00", grant); else passed++;
    total++; if (s0_tready !== 1'b0) $display("FAIL rstmid_s0_tready: got %b, required 0", s0_tready); else passed++;
    total++; if (s1_tready !== 1'b0) $display("FAIL rstmid_s1_tready: got %b, required 0", s1_tready); else passed++;
    total++; if (trunc_err !== 1'b0) $display("FAIL rstmid_trunc_err: got %b, required 0", trunc_err); else passed++;
    rst = 1'b0;
    src1.delete();
    s1_tvalid = 1'b0;
    s1_tlast  = 1'b0;
    s1_tdata  = '0;
    acc1 = 1'b0;
    src0.push_back(mk(8'h51, 1'b1));
    src1.push_back(mk(8'hD1, 1'b1));
    exp_q.push_back(mk(8'h51, 1'b1));
    exp_q.push_back(mk(8'hD1, 1'b1));
    step();
    step();
    total++; if (grant !== 2'b01) $display("FAIL rstmid_ptr_port0: got %b, required 01", grant); else passed++;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) step();
    step();
    total++; if (exp_q.size() !== 0) $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size()); else passed++;
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rst        = 1'b1;
    full_drive = 1'b0;
    fifo_full  = 1'b0;
    s0_tdata   = '0;
    s0_tvalid  = 1'b0;
    s0_tlast   = 1'b0;
    s1_tdata   = '0;
    s1_tvalid  = 1'b0;
    s1_tlast   = 1'b0;
    acc0       = 1'b0;
    acc1       = 1'b0;
    test_reset();
    test_single_port0();
    test_both_two_beat();
    test_round_robin();
    test_fifo_full();
    test_truncation();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
